instruction_fetch: RTL

- Producer side of the instruction path. Fetches 16-bit instruction words from instruction memory over a request/ready handshake.
- Holds each word in an instruction register and presents it to the decoder/controller with a valid/ready handshake.
- Owns the program counter, accepts branch redirects from the controller, and stops on the HALT opcode.
- Sits between instruction memory and the instruction decoder/controller.

---
 rtl/risc_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the instruction path: opcodes, fetch state encoding, word width.
package risc_pkg;

   localparam int INSTR_WIDTH = 16;

   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_LDR  = 3'b011;
   localparam logic [2:0] OP_STR  = 3'b100;
   localparam logic [2:0] OP_BXX  = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [1:0] {
      START  = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory read, single-entry instruction register,
// program counter with branch redirect, stop on HALT.
//
// state  | meaning
// START  | one idle cycle after reset, no handshakes active
// FETCH  | mem_rd high at pc, waiting for mem_ready
// HOLD   | instr valid, waiting for consumer or redirect
// HALTED | HALT consumed, everything ignored until reset
module instruction_fetch
   import risc_pkg::*;
#(
   parameter int                    WIDTH      = 16,
   parameter int                    ADDR_WIDTH = 9,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ready,
   output logic [WIDTH-1:0]      instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted
);

   fetch_state_t          state;
   logic                  redirect_pending;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  is_halt;

   assign is_halt  = (instr[WIDTH-1 -: 3] == OP_HALT);
   assign mem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= START;
         pc               <= RESET_PC;
         instr            <= '0;
         instr_valid      <= 1'b0;
         mem_rd           <= 1'b0;
         halted           <= 1'b0;
         redirect_pending <= 1'b0;
         redirect_target  <= '0;
      end else begin
         case (state)
            START: begin
               state  <= FETCH;
               mem_rd <= 1'b1;
            end
            FETCH: begin
               // The read in flight always completes; a redirect only decides what happens to its data.
               if (mem_ready) begin
                  if (branch_en) begin
                     pc               <= branch_target;
                     redirect_pending <= 1'b0;
                  end else if (redirect_pending) begin
                     pc               <= redirect_target;
                     redirect_pending <= 1'b0;
                  end else begin
                     instr       <= mem_rdata;
                     instr_valid <= 1'b1;
                     mem_rd      <= 1'b0;
                     state       <= HOLD;
                  end
               end else if (branch_en) begin
                  redirect_target  <= branch_target;
                  redirect_pending <= 1'b1;
               end
            end
            HOLD: begin
               if (branch_en) begin
                  pc          <= branch_target;
                  instr_valid <= 1'b0;
                  mem_rd      <= 1'b1;
                  state       <= FETCH;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (is_halt) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc     <= pc + 1'b1;
                     mem_rd <= 1'b1;
                     state  <= FETCH;
                  end
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= START;
            end
         endcase
      end
   end

endmodule
